// File: rtl/local_pattern_table.sv
// local_pattern_table: history-indexed saturating counter table with an in-order training FIFO (LPT_BYPASS_EN forwards a same-cycle update to a lookup of that index)
module local_pattern_table #(
  parameter int HIST_W   = 10,
  parameter int CTR_W    = 2,
  parameter int DEPTH    = 4,
  parameter int CTR_INIT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid_i,
  input  logic [HIST_W-1:0]          hist_i,
  output logic                       req_ready_o,
  output logic                       pred_valid_o,
  output logic                       pred_taken_o,
  output logic [CTR_W-1:0]           pred_ctr_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  output logic                       resolve_error_o,
  output logic [$clog2(DEPTH):0]     inflight_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [HIST_W-1:0] sweep;
  logic [CTR_W-1:0] tbl [2**HIST_W];
  logic [HIST_W-1:0] fifo [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic accept, res_ok;
  logic [HIST_W-1:0] upd_idx;
  logic [CTR_W-1:0] cur, upd, rd;
  always_comb begin
    state_nxt = (state == INIT && &sweep) ? RUN : state;
    req_ready_o = state == RUN && count < CW'(DEPTH);
    accept = req_valid_i && req_ready_o;
    res_ok = resolve_valid_i && state == RUN && count != '0;
    upd_idx = fifo[head];
    cur = tbl[upd_idx];
    upd = resolve_taken_i ? (cur == CTR_MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
`ifdef LPT_BYPASS_EN
    rd = (res_ok && upd_idx == hist_i) ? upd : tbl[hist_i];
`else
    rd = tbl[hist_i];
`endif
  end
  assign pred_taken_o = pred_ctr_o[CTR_W-1];
  assign inflight_count_o = count;
  always_ff @(posedge clock) begin
    if (!reset && state == INIT) tbl[sweep] <= CTR_W'(CTR_INIT);
    else if (!reset && res_ok) tbl[upd_idx] <= upd;
    if (accept) fifo[tail] <= hist_i;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      pred_valid_o <= 1'b0;
      pred_ctr_o <= '0;
      resolve_error_o <= 1'b0;
    end else begin
      state <= state_nxt;
      sweep <= state == INIT ? sweep + 1'b1 : sweep;
      head <= head + PW'(res_ok);
      tail <= tail + PW'(accept);
      count <= count + CW'(accept) - CW'(res_ok);
      pred_valid_o <= accept;
      pred_ctr_o <= accept ? rd : pred_ctr_o;
      resolve_error_o <= resolve_valid_i && !res_ok;
    end
  end
endmodule

// File: tb/tb_local_pattern_table.sv
// tb_local_pattern_table: randomized self-checking bench against a queue/array reference model
module tb_local_pattern_table;
  logic clock = 0, reset = 1, req_valid_i = 0, resolve_valid_i = 0, resolve_taken_i = 0;
  logic [9:0] hist_i = '0;
  logic req_ready_o, pred_valid_o, pred_taken_o, resolve_error_o;
  logic [1:0] pred_ctr_o;
  logic [2:0] inflight_count_o;
  int checks = 0, errors = 0;
  int mdl [1024];
  int q [$];
  int touched [$];
  bit run = 0;
  bit exp_pv, exp_err;
  int exp_ctr = 0, exp_cnt = 0;
  local_pattern_table dut (
    .clock(clock), .reset(reset), .req_valid_i(req_valid_i), .hist_i(hist_i),
    .req_ready_o(req_ready_o), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .pred_ctr_o(pred_ctr_o), .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .resolve_error_o(resolve_error_o), .inflight_count_o(inflight_count_o)
  );
  always #5 clock = ~clock;
  task automatic model_init();
    for (int i = 0; i < 1024; i++) mdl[i] = 1;
    q.delete();
    exp_ctr = 0;
  endtask
  task automatic drive(input bit req, input int h, input bit res, input bit tk);
    int v, idx, nv;
    bit acc, rok;
    req_valid_i = req; hist_i = h[9:0]; resolve_valid_i = res; resolve_taken_i = tk;
    acc = req && run && q.size() < 4;
    rok = res && run && q.size() > 0;
    v = mdl[h];
    if (rok) begin
      idx = q.pop_front();
      nv = tk ? ((mdl[idx] + 1 > 3) ? 3 : mdl[idx] + 1) : ((mdl[idx] - 1 < 0) ? 0 : mdl[idx] - 1);
`ifdef LPT_BYPASS_EN
      if (acc && idx == h) v = nv;
`endif
      mdl[idx] = nv;
    end
    if (acc) begin q.push_back(h); touched.push_back(h); end
    @(posedge clock); #1;
    req_valid_i = 0; resolve_valid_i = 0; resolve_taken_i = 0;
    exp_pv = acc;
    if (acc) exp_ctr = v;
    exp_err = res && !rok;
    exp_cnt = q.size();
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (req_ready_o !== 1'b1 && n < 3000) begin @(posedge clock); #1; n++; end
  endtask
  task automatic test_reset();
    int n;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({req_ready_o, pred_valid_o, pred_taken_o, pred_ctr_o, resolve_error_o, inflight_count_o} !== 9'b0) begin
      errors++; $display("FAIL reset_values: got %b required 0", {req_ready_o, pred_valid_o, pred_taken_o, pred_ctr_o, resolve_error_o, inflight_count_o});
    end
    reset = 0;
    wait_init(n);
    checks++; if (n != 1024) begin errors++; $display("FAIL init_length: got %0d cycles required 1024", n); end
    model_init();
    run = 1;
  endtask
  task automatic test_lookup();
    drive(1, 'h2A, 0, 0);
    checks++; if (pred_valid_o !== 1'b1 || pred_ctr_o !== 2'd1 || pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL first_lookup: got valid=%b ctr=%0d taken=%b required 1/1/0", pred_valid_o, pred_ctr_o, pred_taken_o);
    end
  endtask
  task automatic test_saturation();
    int want;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1);
      drive(1, 'h2A, 0, 0);
      want = (i == 0) ? 2 : 3;
      checks++; if (pred_ctr_o !== want[1:0] || exp_ctr != want) begin
        errors++; $display("FAIL sat_up[%0d]: got %0d required %0d", i, pred_ctr_o, want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      drive(1, 'h2A, 0, 0);
      want = (i < 3) ? 2 - i : 0;
      checks++; if (pred_ctr_o !== want[1:0] || pred_taken_o !== (want >= 2)) begin
        errors++; $display("FAIL sat_down[%0d]: got %0d required %0d", i, pred_ctr_o, want);
      end
    end
    drive(0, 0, 1, 0);
    checks++; if (inflight_count_o !== 3'd0) begin errors++; $display("FAIL sat_drain: count got %0d required 0", inflight_count_o); end
  endtask
  task automatic test_occupancy();
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom_range(0, 1023), 0, 0);
      checks++; if (inflight_count_o !== 3'(i + 1) || pred_valid_o !== 1'b1 || pred_ctr_o !== exp_ctr[1:0]) begin
        errors++; $display("FAIL occ_fill[%0d]: count=%0d ctr=%0d required %0d/%0d", i, inflight_count_o, pred_ctr_o, i + 1, exp_ctr);
      end
    end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL occ_full_ready: got %b required 0", req_ready_o); end
    drive(1, 'h155, 0, 0);
    checks++; if (pred_valid_o !== 1'b0 || inflight_count_o !== 3'd4) begin
      errors++; $display("FAIL occ_fifth: valid=%b count=%0d required 0/4", pred_valid_o, inflight_count_o);
    end
    drive(1, 'h155, 1, 1);
    checks++; if (pred_valid_o !== 1'b0 || inflight_count_o !== 3'd3) begin
      errors++; $display("FAIL occ_full_resolve: valid=%b count=%0d required 0/3", pred_valid_o, inflight_count_o);
    end
    drive(1, $urandom_range(0, 1023), 1, 0);
    checks++; if (pred_valid_o !== 1'b1 || inflight_count_o !== 3'd3 || pred_ctr_o !== exp_ctr[1:0]) begin
      errors++; $display("FAIL occ_push_pop: valid=%b count=%0d ctr=%0d required 1/3/%0d", pred_valid_o, inflight_count_o, pred_ctr_o, exp_ctr);
    end
    for (int i = 2; i >= 0; i--) begin
      drive(0, 0, 1, $urandom_range(0, 1));
      checks++; if (inflight_count_o !== 3'(i)) begin errors++; $display("FAIL occ_drain: count got %0d required %0d", inflight_count_o, i); end
    end
  endtask
  task automatic test_error();
    int snap [$];
    drive(0, 0, 1, 1);
    checks++; if (resolve_error_o !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b required 1", resolve_error_o); end
    @(posedge clock); #1;
    checks++; if (resolve_error_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b required 0", resolve_error_o); end
    snap = touched;
    foreach (snap[i]) begin
      drive(1, snap[i], 0, 0);
      checks++; if (pred_ctr_o !== exp_ctr[1:0] || pred_valid_o !== 1'b1) begin
        errors++; $display("FAIL err_readback[%0h]: got %0d required %0d", snap[i], pred_ctr_o, exp_ctr);
      end
      drive(0, 0, 1, $urandom_range(0, 1));
    end
  endtask
  task automatic test_bypass();
    int n = 0;
    while (mdl['h2A] != 1 && n < 8) begin
      drive(1, 'h2A, 0, 0);
      drive(0, 0, 1, mdl['h2A] < 1);
      n++;
    end
    drive(1, 'h2A, 0, 0);
    drive(1, 'h2A, 1, 1);
`ifdef LPT_BYPASS_EN
    checks++; if (pred_ctr_o !== 2'd2) begin errors++; $display("FAIL bypass_same_cycle: got %0d required 2", pred_ctr_o); end
`else
    checks++; if (pred_ctr_o !== 2'd1) begin errors++; $display("FAIL bypass_same_cycle: got %0d required 1", pred_ctr_o); end
`endif
    drive(1, 'h2A, 0, 0);
    checks++; if (pred_ctr_o !== 2'd2) begin errors++; $display("FAIL bypass_commit: got %0d required 2", pred_ctr_o); end
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++; if (req_ready_o !== (q.size() < 4)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b required %b", i, req_ready_o, q.size() < 4); end
      drive($urandom_range(0, 1), $urandom_range(0, 7) * 37, $urandom_range(0, 2) == 0, $urandom_range(0, 1));
      checks++; if (pred_valid_o !== exp_pv || pred_ctr_o !== exp_ctr[1:0] || resolve_error_o !== exp_err || inflight_count_o !== 3'(exp_cnt)) begin
        errors++; $display("FAIL rnd[%0d]: valid=%b ctr=%0d err=%b count=%0d required %b/%0d/%b/%0d", i, pred_valid_o, pred_ctr_o, resolve_error_o, inflight_count_o, exp_pv, exp_ctr, exp_err, exp_cnt);
      end
    end
  endtask
  task automatic test_reset_mid();
    int n;
    while (q.size() > 0) drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(1, $urandom_range(0, 1023), 0, 0);
    checks++; if (inflight_count_o !== 3'd3) begin errors++; $display("FAIL mid_pre: count got %0d required 3", inflight_count_o); end
    reset = 1; req_valid_i = 1; hist_i = 10'h2A;
    @(posedge clock); #1;
    reset = 0; req_valid_i = 0;
    run = 0; model_init();
    checks++; if (inflight_count_o !== 3'd0 || pred_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset: count=%0d valid=%b ready=%b required 0/0/0", inflight_count_o, pred_valid_o, req_ready_o);
    end
    resolve_valid_i = 1; resolve_taken_i = 1;
    @(posedge clock); #1;
    resolve_valid_i = 0; resolve_taken_i = 0;
    checks++; if (resolve_error_o !== 1'b1 || req_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_init_resolve: err=%b ready=%b required 1/0", resolve_error_o, req_ready_o);
    end
    wait_init(n);
    checks++; if (n != 1023) begin errors++; $display("FAIL mid_init_length: got %0d cycles required 1023", n); end
    run = 1;
    drive(0, 0, 1, 1);
    checks++; if (resolve_error_o !== 1'b1) begin errors++; $display("FAIL mid_post_resolve: got %b required 1", resolve_error_o); end
    drive(1, 'h2A, 0, 0);
    checks++; if (pred_ctr_o !== 2'd1 || pred_valid_o !== 1'b1) begin errors++; $display("FAIL mid_reinit_value: got %0d required 1", pred_ctr_o); end
  endtask
  initial begin
    test_reset();
    test_lookup();
    test_saturation();
    test_occupancy();
    test_error();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
